// File: rtl/ahb_mem.sv
// AHB-Lite subordinate RAM: zero-wait-state byte/halfword/word access with a
// two-cycle ERROR response for unaligned or oversized transfers.
module ahb_mem #(
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int MemDepthWords = 1024
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [AddressWidth-1:0] HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DataWidth-1:0]    HWDATA,
    output logic [DataWidth-1:0]    HRDATA,
    output logic [1:0]              HRESP,
    input  logic                    HREADYin,
    output logic                    HREADYout
);
    localparam int IW = $clog2(MemDepthWords);
    localparam int NL = DataWidth / 8;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idx;
    logic [1:0]      r_lo;
    logic [2:0]      r_size;
    logic            r_write;
    logic            w_accept;
    logic            w_err;
    logic [NL-1:0]   w_be;
    logic [DataWidth-1:0] w_rword;
    logic            w_unused;

    // Burst type and bits above the memory size play no part in addressing.
    assign w_unused = ^{HBURST, HTRANS[0], HADDR[AddressWidth-1:IW+2]};

    assign w_accept = HSEL & HREADYin & HTRANS[1];

    always_comb begin
        w_err = 1'b0;
        case (HSIZE)
            3'd0:    w_err = 1'b0;
            3'd1:    w_err = HADDR[0];
            3'd2:    w_err = |HADDR[1:0];
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = S_IDLE;
        if (r_state == S_ERR1)
            w_state_next = S_ERR2;
        else if (w_accept)
            w_state_next = w_err ? S_ERR1 : S_DATA;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_lo    <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_idx   <= HADDR[IW+1:2];
                r_lo    <= HADDR[1:0];
                r_size  <= HSIZE;
                r_write <= HWRITE;
            end
        end
    end

    always_comb begin
        w_be = '0;
        case (r_size)
            3'd0:    w_be[r_lo] = 1'b1;
            3'd1:    w_be = r_lo[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_be = '1;
            default: w_be = '0;
        endcase
    end

    // One RAM per byte lane; a write lands on the edge closing its data phase.
    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            logic [7:0] r_mem [MemDepthWords];

            always_ff @(posedge HCLK) begin
                if (!HRESET && r_state == S_DATA && r_write && w_be[gi])
                    r_mem[r_idx] <= HWDATA[8*gi +: 8];
            end

            assign w_rword[8*gi +: 8] = r_mem[r_idx];
        end
    endgenerate

    assign HRDATA    = (r_state == S_DATA && !r_write) ? w_rword : '0;
    assign HREADYout = (r_state != S_ERR1);
    assign HRESP     = {1'b0, (r_state == S_ERR1) || (r_state == S_ERR2)};

endmodule

// File: tb/tb_ahb_mem.sv
// Directed bench for ahb_mem: table of single transfers plus hand sequences
// for pipelining, error-phase overlap and mid-transfer reset.
module tb_ahb_mem;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic [1:0]  HRESP;
    logic        HREADYout;
    logic        HREADYin;

    int n_tests = 0;
    int n_fail  = 0;

    assign HREADYin = HREADYout;
    always #5 HCLK = ~HCLK;

    ahb_mem #(.AddressWidth(32), .DataWidth(32), .MemDepthWords(1024)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP),
        .HREADYin(HREADYin), .HREADYout(HREADYout)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic sel, input logic [1:0] trans,
                                input logic write, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rdata);
        vec_t v;
        v.sel = sel; v.trans = trans; v.write = write; v.size = size;
        v.addr = addr; v.wdata = wdata; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic rdy, input logic [1:0] resp,
                           input logic [31:0] rdata);
        chk({tag, ".hreadyout"}, {31'd0, HREADYout}, {31'd0, rdy});
        chk({tag, ".hresp"},     {30'd0, HRESP},     {30'd0, resp});
        chk({tag, ".hrdata"},    HRDATA,             rdata);
    endtask

    // Entered and left at posedge+1; drives one address phase then its data phase.
    task automatic do_xfer(input vec_t v, input string tag);
        HSEL = v.sel; HTRANS = v.trans; HWRITE = v.write;
        HSIZE = v.size; HADDR = v.addr;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'd0; HWDATA = v.wdata;
        if (v.exp_err) begin
            chk_bus({tag, ".err1"}, 1'b0, 2'b01, 32'h0);
            @(posedge HCLK); #1;
            chk_bus({tag, ".err2"}, 1'b1, 2'b01, 32'h0);
        end else begin
            chk_bus({tag, ".data"}, 1'b1, 2'b00, v.exp_rdata);
        end
        @(posedge HCLK); #1;
        chk_bus({tag, ".after"}, 1'b1, 2'b00, 32'h0);
        $display("[TB] %s sel=%0d trans=%0d wr=%0d size=%0d addr=%h wdata=%h err=%0d rdata_exp=%h",
                 tag, v.sel, v.trans, v.write, v.size, v.addr, v.wdata, v.exp_err, v.exp_rdata);
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b1; HADDR = '0; HTRANS = 2'd0; HWRITE = 1'b0;
        HSIZE = 3'd2; HBURST = 3'd0; HWDATA = '0;

        // sel trans wr size addr wdata err rdata
        vecs.push_back(mk(1, 2, 1, 2, 32'h10,   32'hDEADBEEF, 0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 2, 32'h10,   32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 2, 1, 0, 32'h13,   32'hAA000000, 0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 2, 32'h10,   32'h0,        0, 32'hAAADBEEF));
        vecs.push_back(mk(1, 2, 1, 1, 32'h10,   32'h00001234, 0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 2, 32'h10,   32'h0,        0, 32'hAAAD1234));
        vecs.push_back(mk(1, 2, 1, 1, 32'h11,   32'hFFFFFFFF, 1, 32'h0));
        vecs.push_back(mk(1, 2, 0, 2, 32'h10,   32'h0,        0, 32'hAAAD1234));
        vecs.push_back(mk(1, 2, 0, 2, 32'h02,   32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 2, 0, 3, 32'h10,   32'h0,        1, 32'h0));
        vecs.push_back(mk(1, 3, 1, 3, 32'h10,   32'hFFFFFFFF, 1, 32'h0));
        vecs.push_back(mk(1, 0, 1, 2, 32'h10,   32'hFFFFFFFF, 0, 32'h0));
        vecs.push_back(mk(1, 1, 1, 2, 32'h10,   32'hFFFFFFFF, 0, 32'h0));
        vecs.push_back(mk(0, 2, 1, 2, 32'h10,   32'hFFFFFFFF, 0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 2, 32'h10,   32'h0,        0, 32'hAAAD1234));
        vecs.push_back(mk(1, 2, 1, 2, 32'h14,   32'hCAFEF00D, 0, 32'h0));
        vecs.push_back(mk(1, 2, 1, 1, 32'h16,   32'h56780000, 0, 32'h0));
        vecs.push_back(mk(1, 3, 1, 0, 32'h15,   32'h00003300, 0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 2, 32'h14,   32'h0,        0, 32'h5678330D));
        vecs.push_back(mk(1, 2, 0, 1, 32'h16,   32'h0,        0, 32'h5678330D));
        vecs.push_back(mk(1, 2, 0, 0, 32'h11,   32'h0,        0, 32'hAAAD1234));
        vecs.push_back(mk(1, 2, 1, 2, 32'h1020, 32'h22222222, 0, 32'h0));
        vecs.push_back(mk(1, 2, 0, 2, 32'h20,   32'h0,        0, 32'h22222222));

        repeat (3) @(posedge HCLK);
        #1;
        chk_bus("reset", 1'b1, 2'b00, 32'h0);
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        foreach (vecs[i]) do_xfer(vecs[i], $sformatf("vec%0d", i));

        // Pipelined write then read of the same word.
        HSEL = 1; HTRANS = 2'd2; HWRITE = 1; HSIZE = 3'd2; HADDR = 32'h20;
        @(posedge HCLK); #1;
        HWDATA = 32'h11111111; HWRITE = 0; HADDR = 32'h20; HTRANS = 2'd2;
        chk_bus("b2b.wr", 1'b1, 2'b00, 32'h0);
        @(posedge HCLK); #1;
        HTRANS = 2'd0;
        chk_bus("b2b.rd", 1'b1, 2'b00, 32'h11111111);
        @(posedge HCLK); #1;
        chk_bus("b2b.idle", 1'b1, 2'b00, 32'h0);
        $display("[TB] b2b write/read 0x20 = 11111111");

        // Error; a write offered during ERR1 must be ignored, a read in ERR2 accepted.
        HTRANS = 2'd2; HWRITE = 1; HSIZE = 3'd1; HADDR = 32'h11;
        @(posedge HCLK); #1;
        HWDATA = 32'h0; HTRANS = 2'd2; HWRITE = 1; HSIZE = 3'd2; HADDR = 32'h20;
        chk_bus("errpipe.err1", 1'b0, 2'b01, 32'h0);
        @(posedge HCLK); #1;
        HWDATA = 32'hBAD0BAD0; HWRITE = 0; HADDR = 32'h20;
        chk_bus("errpipe.err2", 1'b1, 2'b01, 32'h0);
        @(posedge HCLK); #1;
        HTRANS = 2'd0;
        chk_bus("errpipe.rd", 1'b1, 2'b00, 32'h11111111);
        @(posedge HCLK); #1;
        $display("[TB] error then read in ERR2 0x20 = 11111111");

        // Reset during a write data phase drops the write.
        do_xfer(mk(1, 2, 1, 2, 32'h30, 32'h12345678, 0, 32'h0), "rst.pre");
        HTRANS = 2'd2; HWRITE = 1; HSIZE = 3'd2; HADDR = 32'h30;
        @(posedge HCLK); #1;
        HTRANS = 2'd0; HWDATA = 32'hFFFFFFFF; HRESET = 1;
        @(posedge HCLK); #1;
        HRESET = 0;
        chk_bus("rst.mid", 1'b1, 2'b00, 32'h0);
        do_xfer(mk(1, 2, 0, 2, 32'h30, 32'h0, 0, 32'h12345678), "rst.read");

        // Reset during ERR1 aborts the error sequence.
        HTRANS = 2'd2; HWRITE = 0; HSIZE = 3'd1; HADDR = 32'h11;
        @(posedge HCLK); #1;
        HTRANS = 2'd0; HRESET = 1;
        chk_bus("rsterr.err1", 1'b0, 2'b01, 32'h0);
        @(posedge HCLK); #1;
        HRESET = 0;
        chk_bus("rsterr.after", 1'b1, 2'b00, 32'h0);
        $display("[TB] reset during ERR1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
